// File: rtl/conv1d_pkg.sv
// +--------------------------------------------------------------------------+
// | Module      : conv1d_pkg                                                 |
// | Description : Shared constants and types for the 1D convolution          |
// |               sequencer: default geometry, FSM state encoding and the    |
// |               packed command record.                                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

package conv1d_pkg;

  localparam int DEF_FRAME_SIZE  = 50;
  localparam int DEF_NUM_FILTERS = 8;
  localparam int DEF_FILTER_SIZE = 3;

  localparam int DEF_FILTER_W = $clog2(DEF_NUM_FILTERS);
  localparam int DEF_POS_W    = $clog2(DEF_FRAME_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One command as seen by the weight bank / window shift register
  // (default geometry).
  typedef struct packed {
    logic [DEF_FILTER_W-1:0]    filter;
    logic [DEF_POS_W-1:0]       pos;
    logic [DEF_FILTER_SIZE-1:0] pad;
    logic                       first;
    logic                       last;
  } cmd_t;

endpackage

`default_nettype wire

// File: rtl/conv1d_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | Module      : conv1d_ctrl_if                                             |
// | Description : Job-start and command handshake bundle of conv1d_ctrl.     |
// |   start_valid_i / start_ready_o : job start handshake                    |
// |   cmd_filter_o, cmd_pos_o, cmd_pad_o, cmd_first_o, cmd_last_o : command  |
// |   valid_o / ready_i / last_o    : command handshake, final-command flag  |
// |   busy_o, done_o                : job status                             |
// |   master = controller side, slave = consumer/driver side                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

interface conv1d_ctrl_if
  import conv1d_pkg::*;
#(
  parameter int FRAME_SIZE  = DEF_FRAME_SIZE,
  parameter int NUM_FILTERS = DEF_NUM_FILTERS,
  parameter int FILTER_SIZE = DEF_FILTER_SIZE
) ();

  logic                           start_valid_i;
  logic                           start_ready_o;
  logic [$clog2(NUM_FILTERS)-1:0] cmd_filter_o;
  logic [$clog2(FRAME_SIZE)-1:0]  cmd_pos_o;
  logic [FILTER_SIZE-1:0]         cmd_pad_o;
  logic                           cmd_first_o;
  logic                           cmd_last_o;
  logic                           valid_o;
  logic                           last_o;
  logic                           ready_i;
  logic                           busy_o;
  logic                           done_o;

  modport master (
    input  start_valid_i, ready_i,
    output start_ready_o, cmd_filter_o, cmd_pos_o, cmd_pad_o,
           cmd_first_o, cmd_last_o, valid_o, last_o, busy_o, done_o
  );

  modport slave (
    output start_valid_i, ready_i,
    input  start_ready_o, cmd_filter_o, cmd_pos_o, cmd_pad_o,
           cmd_first_o, cmd_last_o, valid_o, last_o, busy_o, done_o
  );

endinterface

`default_nettype wire

// File: rtl/conv1d_ctrl_counter.sv
// +--------------------------------------------------------------------------+
// | Module      : conv1d_ctrl_counter                                        |
// | Description : Wrapping counter 0..MAX with synchronous clear and         |
// |               increment enable.                                          |
// |   clk_i, rst_i_n : clock, asynchronous active-low reset                  |
// |   clr_i          : force to 0 (priority over en_i)                       |
// |   en_i           : advance; wraps to 0 when at MAX                        |
// |   count_o        : current value                                         |
// |   next_o         : value after this edge (combinational)                  |
// |   tc_o           : count_o == MAX                                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module conv1d_ctrl_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 15
) (
  input  logic             clk_i,
  input  logic             rst_i_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] next_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q, count_d;

  assign tc_o = (count_q == WIDTH'(MAX));

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = tc_o ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i_n) begin
    if (!rst_i_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign next_o  = count_d;

endmodule

`default_nettype wire

// File: rtl/conv1d_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module      : conv1d_ctrl                                                |
// | Description : Sequencer for the 1D convolution datapath. Accepts one     |
// |               job per buffered frame and issues one command per          |
// |               (filter, position) step, filter outer / position inner.    |
// |   clk_i, rst_i_n : clock, asynchronous active-low reset                  |
// |   bus (master)   : start handshake, command bus, status (conv1d_ctrl_if) |
// | Config macro : CONV1D_CTRL_PAD_EN - "same" convolution with zero-pad     |
// |                mask; undefined gives "valid" convolution, mask = 0.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module conv1d_ctrl
  import conv1d_pkg::*;
#(
  parameter int FRAME_SIZE  = DEF_FRAME_SIZE,
  parameter int NUM_FILTERS = DEF_NUM_FILTERS,
  parameter int FILTER_SIZE = DEF_FILTER_SIZE
) (
  input  logic          clk_i,
  input  logic          rst_i_n,
  conv1d_ctrl_if.master bus
);

`ifdef CONV1D_CTRL_PAD_EN
  localparam int H     = (FILTER_SIZE - 1) / 2;
  localparam int P_MAX = FRAME_SIZE - 1;
`else
  localparam int P_MAX = FRAME_SIZE - FILTER_SIZE;
`endif
  localparam int FW = $clog2(NUM_FILTERS);
  localparam int PW = $clog2(FRAME_SIZE);

  state_e state_q, state_d;

  logic [FW-1:0]          filter_cnt, filter_next;
  logic [PW-1:0]          pos_cnt, pos_next;
  logic                   filter_tc, pos_tc;
  logic [FILTER_SIZE-1:0] pad_next;

  logic [FILTER_SIZE-1:0] pad_q, pad_d;
  logic                   first_q, first_d;
  logic                   last_q, last_d;
  logic                   jlast_q, jlast_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic start_hs, hs, final_hs;

  assign start_hs = (state_q == ST_IDLE) & bus.start_valid_i;
  assign hs       = valid_q & bus.ready_i;
  assign final_hs = hs & pos_tc & filter_tc;

  conv1d_ctrl_counter #(.WIDTH(PW), .MAX(P_MAX)) u_pos_cnt (
    .clk_i   (clk_i),
    .rst_i_n (rst_i_n),
    .clr_i   (start_hs),
    .en_i    (hs),
    .count_o (pos_cnt),
    .next_o  (pos_next),
    .tc_o    (pos_tc)
  );

  conv1d_ctrl_counter #(.WIDTH(FW), .MAX(NUM_FILTERS - 1)) u_filter_cnt (
    .clk_i   (clk_i),
    .rst_i_n (rst_i_n),
    .clr_i   (start_hs),
    .en_i    (hs & pos_tc),
    .count_o (filter_cnt),
    .next_o  (filter_next),
    .tc_o    (filter_tc)
  );

  // Tap k reads sample pos+k-H; flag it when that falls outside the frame.
  // Computed from the counter's next value so it lands with the command.
`ifdef CONV1D_CTRL_PAD_EN
  logic [31:0] pos_next_w;
  assign pos_next_w = 32'(pos_next);
  for (genvar k = 0; k < FILTER_SIZE; k++) begin : g_pad
    assign pad_next[k] = ((pos_next_w + 32'(k)) < 32'(H)) ||
                         ((pos_next_w + 32'(k)) >= 32'(FRAME_SIZE + H));
  end
`else
  assign pad_next = '0;
`endif

  always_comb begin
    state_d = state_q;
    pad_d   = pad_q;
    first_d = first_q;
    last_d  = last_q;
    jlast_d = jlast_q;

    case (state_q)
      ST_IDLE: if (bus.start_valid_i) state_d = ST_RUN;
      ST_RUN:  if (final_hs)          state_d = ST_DONE;
      ST_DONE:                        state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase

    // Command fields only move on a start or a handshake, so they hold
    // under backpressure; after the final command they return to zero.
    if (final_hs) begin
      pad_d   = '0;
      first_d = 1'b0;
      last_d  = 1'b0;
      jlast_d = 1'b0;
    end else if (start_hs || hs) begin
      pad_d   = pad_next;
      first_d = (pos_next == '0);
      last_d  = (pos_next == PW'(P_MAX));
      jlast_d = (pos_next == PW'(P_MAX)) && (filter_next == FW'(NUM_FILTERS - 1));
    end

    valid_d = (state_d == ST_RUN);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_i_n) begin
    if (!rst_i_n) begin
      state_q <= ST_IDLE;
      pad_q   <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      jlast_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pad_q   <= pad_d;
      first_q <= first_d;
      last_q  <= last_d;
      jlast_q <= jlast_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.start_ready_o = (state_q == ST_IDLE);
  assign bus.cmd_filter_o  = filter_cnt;
  assign bus.cmd_pos_o     = pos_cnt;
  assign bus.cmd_pad_o     = pad_q;
  assign bus.cmd_first_o   = first_q;
  assign bus.cmd_last_o    = last_q;
  assign bus.valid_o       = valid_q;
  assign bus.last_o        = jlast_q;
  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;

endmodule

`default_nettype wire
